// File: rtl/dump_readout_arbiter.sv
// Round-robin readout of per-channel E/P/L I/Q dumps onto one valid/ready word stream.
// Optional ARB_EPOCH_EN appends an 11-bit epoch word; records are then 7 words.
module dump_readout_arbiter #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 16,
    parameter int CH_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          dump,
    input  logic [NUM_CH*6*WORD_W-1:0] acc_data,
`ifdef ARB_EPOCH_EN
    input  logic [NUM_CH*11-1:0]       epoch_data,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_data,
    output logic [CH_W-1:0]            out_ch,
    output logic [2:0]                 out_word,
    output logic                       out_last,
    output logic [NUM_CH-1:0]          overrun,
    input  logic [NUM_CH-1:0]          clr_overrun
);

`ifdef ARB_EPOCH_EN
    localparam int NWORDS = 7;
`else
    localparam int NWORDS = 6;
`endif
    localparam logic [2:0] LAST_WORD = 3'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   overrun_q, overrun_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [2:0]          word_q, word_d;
    logic [WORD_W-1:0]   snap_q [NWORDS];
    logic [WORD_W-1:0]   snap_d [NWORDS];

    logic                grant_found;
    logic [CH_W-1:0]     grant_ch;
    logic                do_grant;
    logic [NUM_CH-1:0]   grant_vec;

    // Walk offsets from farthest to nearest so the channel right after rr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pending_q[idx]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        ch_d     = ch_q;
        rr_d     = rr_q;
        snap_d   = snap_q;
        do_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) do_grant = 1'b1;
            end
            SEND: begin
                if (out_ready) begin
                    if (word_q == LAST_WORD) begin
                        // Back-to-back regrant keeps the stream bubble-free.
                        if (grant_found) begin
                            do_grant = 1'b1;
                        end else begin
                            state_d = IDLE;
                            word_d  = '0;
                        end
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            int base;
            base    = int'(grant_ch) * 6 * WORD_W;
            state_d = SEND;
            word_d  = '0;
            ch_d    = grant_ch;
            rr_d    = grant_ch;
            for (int w = 0; w < 6; w++) begin
                snap_d[w] = acc_data[base + w*WORD_W +: WORD_W];
            end
`ifdef ARB_EPOCH_EN
            snap_d[6] = WORD_W'(epoch_data[int'(grant_ch)*11 +: 11]);
`endif
        end
    end

    // A dump in the grant cycle re-arms pending without counting as an overrun.
    always_comb begin
        grant_vec = '0;
        if (do_grant) grant_vec[grant_ch] = 1'b1;
        pending_d = (pending_q & ~grant_vec) | dump;
        overrun_d = (overrun_q & ~clr_overrun) | (dump & pending_q & ~grant_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            rr_q      <= '0;
            ch_q      <= '0;
            word_q    <= '0;
            for (int w = 0; w < NWORDS; w++) snap_q[w] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_q      <= rr_d;
            ch_q      <= ch_d;
            word_q    <= word_d;
            snap_q    <= snap_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (word_q == 3'(w)) out_data = snap_q[w];
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_ch    = ch_q;
    assign out_word  = word_q;
    assign out_last  = (word_q == LAST_WORD);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dump_readout_arbiter.sv
// Directed bench for dump_readout_arbiter: latency, round-robin order, stall, re-dump, overrun, reset.
module tb_dump_readout_arbiter;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 16;
    localparam int CH_W   = 2;
`ifdef ARB_EPOCH_EN
    localparam int NW = 7;
`else
    localparam int NW = 6;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH-1:0]          dump;
    logic [NUM_CH*6*WORD_W-1:0] acc_data;
`ifdef ARB_EPOCH_EN
    logic [NUM_CH*11-1:0]       epoch_data = '0;
`endif
    logic                       out_valid;
    logic                       out_ready;
    logic [WORD_W-1:0]          out_data;
    logic [CH_W-1:0]            out_ch;
    logic [2:0]                 out_word;
    logic                       out_last;
    logic [NUM_CH-1:0]          overrun;
    logic [NUM_CH-1:0]          clr_overrun;

    int n_assert = 0;
    int n_fail   = 0;

    dump_readout_arbiter #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .CH_W(CH_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .dump        (dump),
        .acc_data    (acc_data),
`ifdef ARB_EPOCH_EN
        .epoch_data  (epoch_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_word    (out_word),
        .out_last    (out_last),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_acc(input int ch, input logic [15:0] base);
        for (int w = 0; w < 6; w++) acc_data[ch*6*WORD_W + w*WORD_W +: WORD_W] = base + 16'(w + 1);
    endtask

    task automatic expect_word(input string tag, input int ch, input logic [15:0] base, input int w);
        logic [15:0] exp_d;
        exp_d = (w < 6) ? base + 16'(w + 1) : 16'h0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_word"},  32'(out_word),  32'(w));
        chk({tag, "_data"},  32'(out_data),  32'(exp_d));
        chk({tag, "_last"},  32'(out_last),  32'(w == NW - 1));
    endtask

    // Checks one full record starting at the current word-0 sample, ready held high
    // except for an optional 5-cycle stall; optionally re-dumps the same channel mid-record.
    task automatic check_rec(input string tag, input int ch, input logic [15:0] base,
                             input int stall_at, input int redump_at, input logic [15:0] new_base);
        for (int w = 0; w < NW; w++) begin
            if (w == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    expect_word({tag, "_stall"}, ch, base, w);
                    step();
                end
                out_ready = 1'b1;
            end
            expect_word(tag, ch, base, w);
            if (w == redump_at) begin
                dump[ch] = 1'b1;
                set_acc(ch, new_base);
            end
            step();
            dump = '0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        dump        = '0;
        acc_data    = '0;
        out_ready   = 1'b1;
        clr_overrun = '0;
        step();
        do_reset();

        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun),   32'd0);
        chk("rst_data",    32'(out_data),  32'd0);
        chk("rst_ch",      32'(out_ch),    32'd0);
        chk("rst_word",    32'(out_word),  32'd0);
        chk("rst_last",    32'(out_last),  32'd0);

        // Single dump on ch2: valid two edges after the dump edge.
        set_acc(2, 16'h0000);
        dump = 4'b0100;
        step();
        dump = '0;
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        step();
        check_rec("t1", 2, 16'h0000, -1, -1, 16'h0);
        chk("t1_idle_after", 32'(out_valid), 32'd0);

        // All four dump together after reset: order 1,2,3,0 with no gaps.
        do_reset();
        for (int k = 0; k < NUM_CH; k++) set_acc(k, 16'(k * 16'h100));
        dump = 4'b1111;
        step();
        dump = '0;
        step();
        check_rec("rr1", 1, 16'h0100, -1, -1, 16'h0);
        check_rec("rr2", 2, 16'h0200, -1, -1, 16'h0);
        check_rec("rr3", 3, 16'h0300, -1, -1, 16'h0);
        check_rec("rr0", 0, 16'h0000, -1, -1, 16'h0);
        chk("rr_idle_after", 32'(out_valid), 32'd0);
        chk("rr_overrun",    32'(overrun),   32'd0);

        // Stall 5 cycles on word 3 of a ch3 record.
        dump = 4'b1000;
        step();
        dump = '0;
        wait_valid("stall");
        check_rec("stl", 3, 16'h0300, 3, -1, 16'h0);
        chk("stl_idle_after", 32'(out_valid), 32'd0);

        // Re-dump ch1 with new data mid-record: old snapshot finishes, new record follows.
        dump = 4'b0010;
        step();
        dump = '0;
        wait_valid("redump");
        check_rec("rd_old", 1, 16'h0100, -1, 2, 16'h0150);
        check_rec("rd_new", 1, 16'h0150, -1, -1, 16'h0);
        chk("rd_idle_after", 32'(out_valid), 32'd0);
        chk("rd_overrun",    32'(overrun),   32'd0);

        // Overrun on ch0 while ch2 holds the stream stalled.
        set_acc(2, 16'h0A00);
        set_acc(0, 16'h0B00);
        out_ready = 1'b0;
        dump = 4'b0100;
        step();
        dump = '0;
        step();
        chk("ov_busy_valid", 32'(out_valid), 32'd1);
        dump = 4'b0001;
        step();
        dump = '0;
        repeat (9) step();
        chk("ov_before", 32'(overrun), 32'd0);
        dump = 4'b0001;
        step();
        dump = '0;
        chk("ov_set", 32'(overrun), 32'b0001);
        dump        = 4'b0001;
        clr_overrun = 4'b0001;
        step();
        dump        = '0;
        clr_overrun = '0;
        chk("ov_set_wins", 32'(overrun), 32'b0001);
        clr_overrun = 4'b0001;
        step();
        clr_overrun = '0;
        chk("ov_cleared", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        check_rec("ov_ch2", 2, 16'h0A00, -1, -1, 16'h0);
        check_rec("ov_ch0", 0, 16'h0B00, -1, -1, 16'h0);
        chk("ov_idle_after", 32'(out_valid), 32'd0);

        // Reset in the middle of a ch3 record with ch1 pending and overrun.
        set_acc(3, 16'h0C00);
        dump = 4'b1000;
        step();
        dump = '0;
        wait_valid("mrst");
        chk("mrst_w0", 32'(out_word), 32'd0);
        dump = 4'b0010;
        step();
        dump = 4'b0010;
        step();
        dump = '0;
        chk("mrst_overrun_pre", 32'(overrun),  32'b0010);
        chk("mrst_w2",          32'(out_word), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid",   32'(out_valid), 32'd0);
        chk("mrst_overrun", 32'(overrun),   32'd0);
        chk("mrst_word",    32'(out_word),  32'd0);
        repeat (3) step();
        chk("mrst_no_pending", 32'(out_valid), 32'd0);
        dump = 4'b1000;
        step();
        dump = '0;
        step();
        check_rec("mrst_new", 3, 16'h0C00, -1, -1, 16'h0);
        chk("mrst_idle_after", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
